// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: shared GPIO pad configuration word layout and default values
// Used by the serial loader and by every per-pad receiver so field positions live in one place.
package gpio_cfg_pkg;
    localparam int CTRL_BITS = 13;
    localparam int MGMT_ENA  = 0;
    localparam int OEB       = 1;
    localparam int HLDH      = 2;
    localparam int INP_DIS   = 3;
    localparam int IB_MODE   = 4;
    localparam int ANA_EN    = 5;
    localparam int ANA_SEL   = 6;
    localparam int ANA_POL   = 7;
    localparam int SLOW      = 8;
    localparam int VTRIP     = 9;
    localparam int DM_LSB    = 10;
    localparam int DM_W      = 3;
    localparam logic [CTRL_BITS-1:0] CFG_BIDIR = 13'h1801;
    localparam logic [CTRL_BITS-1:0] CFG_INPUT = 13'h0403;
endpackage

// File: rtl/serial_sync.sv
// serial_sync: STAGES-deep 1-bit synchronizer, async active-low reset to 0
// Ports: clk, resetn (async, active-low), d (async input), q (synchronized output).
module serial_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = STAGES'({sync_q, d});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/gpio_serial_ctrl.sv
// gpio_serial_ctrl: per-pad receiver of the GPIO serial configuration chain
// Ports: clk, resetn (async, active-low); serial_{clock,resetn,data}_in from upstream,
// serial_{clock,resetn,data}_out to downstream; pad_ctrl shadow word and its decoded
// mode fields; load_pulse high in the cycle pad_ctrl updates.
module gpio_serial_ctrl #(
    parameter int                                 CTRL_BITS   = gpio_cfg_pkg::CTRL_BITS,
    parameter logic [gpio_cfg_pkg::CTRL_BITS-1:0] RESET_VAL   = gpio_cfg_pkg::CFG_INPUT,
    parameter int                                 SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 serial_clock_in,
    input  logic                 serial_resetn_in,
    input  logic                 serial_data_in,
    output logic                 serial_clock_out,
    output logic                 serial_resetn_out,
    output logic                 serial_data_out,
    output logic [CTRL_BITS-1:0] pad_ctrl,
    output logic                 mgmt_ena,
    output logic                 gpio_outenb,
    output logic                 gpio_holdover,
    output logic                 gpio_inenb,
    output logic                 gpio_ib_mode_sel,
    output logic                 gpio_ana_en,
    output logic                 gpio_ana_sel,
    output logic                 gpio_ana_pol,
    output logic                 gpio_slow_sel,
    output logic                 gpio_vtrip_sel,
    output logic [2:0]           gpio_dm,
    output logic                 load_pulse
);
    import gpio_cfg_pkg::*;

    logic                 s_clk, s_rst, s_dat;
    logic                 s_clk_d_q, s_rst_d_q;
    logic                 rise, fall, rfall, clear, load;
    logic [CTRL_BITS-1:0] shift_q, shift_d, pad_ctrl_q, pad_ctrl_d;
    logic                 data_out_q, data_out_d, load_pulse_q, load_pulse_d;

    serial_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (.clk(clk), .resetn(resetn), .d(serial_clock_in),  .q(s_clk));
    serial_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (.clk(clk), .resetn(resetn), .d(serial_resetn_in), .q(s_rst));
    serial_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (.clk(clk), .resetn(resetn), .d(serial_data_in),   .q(s_dat));

    always_comb begin
        rise         = s_clk & ~s_clk_d_q;
        fall         = ~s_clk & s_clk_d_q;
        rfall        = ~s_rst & s_rst_d_q;
        // Reset low with the chain clock low is a clear; low with the clock high is a load.
        clear        = ~s_rst & ~s_clk;
        load         = rfall & s_clk;
        shift_d      = clear ? '0 : (rise & s_rst) ? {shift_q[CTRL_BITS-2:0], s_dat} : shift_q;
        pad_ctrl_d   = load ? shift_q : pad_ctrl_q;
        load_pulse_d = load;
        // Outgoing data moves with the forwarded falling edge so it is stable across the high phase.
        data_out_d   = fall ? shift_q[CTRL_BITS-1] : data_out_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_clk_d_q    <= 1'b0;
            s_rst_d_q    <= 1'b0;
            shift_q      <= '0;
            pad_ctrl_q   <= RESET_VAL;
            data_out_q   <= 1'b0;
            load_pulse_q <= 1'b0;
        end else begin
            s_clk_d_q    <= s_clk;
            s_rst_d_q    <= s_rst;
            shift_q      <= shift_d;
            pad_ctrl_q   <= pad_ctrl_d;
            data_out_q   <= data_out_d;
            load_pulse_q <= load_pulse_d;
        end
    end

    assign serial_clock_out  = s_clk_d_q;
    assign serial_resetn_out = s_rst_d_q;
    assign serial_data_out   = data_out_q;
    assign pad_ctrl          = pad_ctrl_q;
    assign load_pulse        = load_pulse_q;
    assign mgmt_ena          = pad_ctrl_q[MGMT_ENA];
    assign gpio_outenb       = pad_ctrl_q[OEB];
    assign gpio_holdover     = pad_ctrl_q[HLDH];
    assign gpio_inenb        = pad_ctrl_q[INP_DIS];
    assign gpio_ib_mode_sel  = pad_ctrl_q[IB_MODE];
    assign gpio_ana_en       = pad_ctrl_q[ANA_EN];
    assign gpio_ana_sel      = pad_ctrl_q[ANA_SEL];
    assign gpio_ana_pol      = pad_ctrl_q[ANA_POL];
    assign gpio_slow_sel     = pad_ctrl_q[SLOW];
    assign gpio_vtrip_sel    = pad_ctrl_q[VTRIP];
    assign gpio_dm           = pad_ctrl_q[DM_LSB +: DM_W];
endmodule

// File: tb/tb_gpio_serial_ctrl.sv
// tb_gpio_serial_ctrl: three-pad chain bench with a serial-level model and load scoreboard
module tb_gpio_serial_ctrl;
    typedef struct {
        int          idx;
        logic [12:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn, sclk, srst, sdat;
    logic        co [3];
    logic        ro [3];
    logic        dout [3];
    logic [12:0] pc [3];
    logic        lp [3];
    logic        me [3], oe [3], hl [3], ie [3], ib [3], ae [3], asl [3], ap [3], sl [3], vt [3];
    logic [2:0]  dm [3];

    logic [12:0] m_sh [3];
    logic        m_do [3];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_do, prev_co, prev_rn;

    always #5 clk = ~clk;

    gpio_serial_ctrl #(.RESET_VAL(13'h1801)) u0 (
        .clk(clk), .resetn(resetn),
        .serial_clock_in(sclk), .serial_resetn_in(srst), .serial_data_in(sdat),
        .serial_clock_out(co[0]), .serial_resetn_out(ro[0]), .serial_data_out(dout[0]),
        .pad_ctrl(pc[0]), .mgmt_ena(me[0]), .gpio_outenb(oe[0]), .gpio_holdover(hl[0]),
        .gpio_inenb(ie[0]), .gpio_ib_mode_sel(ib[0]), .gpio_ana_en(ae[0]), .gpio_ana_sel(asl[0]),
        .gpio_ana_pol(ap[0]), .gpio_slow_sel(sl[0]), .gpio_vtrip_sel(vt[0]), .gpio_dm(dm[0]),
        .load_pulse(lp[0])
    );

    gpio_serial_ctrl #(.RESET_VAL(13'h0403)) u1 (
        .clk(clk), .resetn(resetn),
        .serial_clock_in(co[0]), .serial_resetn_in(ro[0]), .serial_data_in(dout[0]),
        .serial_clock_out(co[1]), .serial_resetn_out(ro[1]), .serial_data_out(dout[1]),
        .pad_ctrl(pc[1]), .mgmt_ena(me[1]), .gpio_outenb(oe[1]), .gpio_holdover(hl[1]),
        .gpio_inenb(ie[1]), .gpio_ib_mode_sel(ib[1]), .gpio_ana_en(ae[1]), .gpio_ana_sel(asl[1]),
        .gpio_ana_pol(ap[1]), .gpio_slow_sel(sl[1]), .gpio_vtrip_sel(vt[1]), .gpio_dm(dm[1]),
        .load_pulse(lp[1])
    );

    gpio_serial_ctrl #(.RESET_VAL(13'h0403)) u2 (
        .clk(clk), .resetn(resetn),
        .serial_clock_in(co[1]), .serial_resetn_in(ro[1]), .serial_data_in(dout[1]),
        .serial_clock_out(co[2]), .serial_resetn_out(ro[2]), .serial_data_out(dout[2]),
        .pad_ctrl(pc[2]), .mgmt_ena(me[2]), .gpio_outenb(oe[2]), .gpio_holdover(hl[2]),
        .gpio_inenb(ie[2]), .gpio_ib_mode_sel(ib[2]), .gpio_ana_en(ae[2]), .gpio_ana_sel(asl[2]),
        .gpio_ana_pol(ap[2]), .gpio_slow_sel(sl[2]), .gpio_vtrip_sel(vt[2]), .gpio_dm(dm[2]),
        .load_pulse(lp[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load scoreboard and forwarded-data edge alignment, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (lp[i]) begin
                if (sb.size() == 0) check("unexp_load", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("load_idx", i, e.idx);
                    check("pad_ctrl", {19'b0, pc[i]}, {19'b0, e.val});
                end
            end
        end
        if (resetn && prev_rn && dout[0] !== prev_do)
            check("do_on_fall", {30'b0, prev_co, co[0]}, 32'b10);
        prev_do = dout[0];
        prev_co = co[0];
        prev_rn = resetn;
    end

    task automatic sbit(input logic b, input logic same);
        if (sclk) begin
            sclk = 1'b0;
            for (int i = 0; i < 3; i++) m_do[i] = m_sh[i][12];
        end
        if (!same) sdat = b;
        @(negedge clk);
        sclk = 1'b1;
        sdat = b;
        for (int i = 0; i < 3; i++) m_sh[i] = {m_sh[i][11:0], (i == 0) ? b : m_do[i-1]};
        @(negedge clk);
    endtask

    task automatic shift_word(input logic [12:0] w, input logic first_same);
        for (int k = 12; k >= 0; k--) sbit(w[k], first_same && k == 12);
    endtask

    task automatic settle_check();
        check("shift0", {19'b0, u0.shift_q}, {19'b0, m_sh[0]});
        check("shift1", {19'b0, u1.shift_q}, {19'b0, m_sh[1]});
        check("shift2", {19'b0, u2.shift_q}, {19'b0, m_sh[2]});
        for (int i = 0; i < 3; i++) check("dout", {31'b0, dout[i]}, {31'b0, m_do[i]});
    endtask

    task automatic clear_chain();
        if (sclk) begin
            sclk = 1'b0;
            for (int i = 0; i < 3; i++) m_do[i] = m_sh[i][12];
            @(negedge clk);
        end
        srst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) m_sh[i] = '0;
        srst = 1'b1;
        repeat (12) @(negedge clk);
        settle_check();
    endtask

    task automatic load_chain();
        int n;
        for (int i = 0; i < 3; i++) sb.push_back('{idx: i, val: m_sh[i]});
        srst = 1'b0;
        n = 0;
        do begin
            n++;
            @(posedge clk);
            #1;
        end while (!lp[0] && n < 8);
        check("load_lat", n, 3);
        @(posedge clk);
        #1;
        check("load_1cyc", {31'b0, lp[0]}, 0);
        @(negedge clk);
        srst = 1'b1;
        repeat (12) @(negedge clk);
        settle_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0;
        sclk = 1'b0;
        srst = 1'b1;
        sdat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_sh[i] = '0;
            m_do[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_pc_bidir", {19'b0, pc[0]}, 32'h1801);
        check("rst_dm_bidir", {29'b0, dm[0]}, 32'b110);
        check("rst_mgmt_ena", {31'b0, me[0]}, 1);
        check("rst_ser_out", {29'b0, co[0], ro[0], dout[0]}, 0);
        check("rst_lp", {31'b0, lp[0]}, 0);
        check("rst_pc_input", {19'b0, pc[1]}, 32'h0403);
        check("rst_oeb_input", {31'b0, oe[1]}, 1);
        check("rst_dm_input", {29'b0, dm[1]}, 32'b001);
        resetn = 1'b1;
        repeat (12) @(negedge clk);

        sclk = 1'b1;
        for (int i = 0; i < 3; i++) m_sh[i] = {m_sh[i][11:0], (i == 0) ? 1'b0 : m_do[i-1]};
        n = 0;
        do begin
            n++;
            @(posedge clk);
            #1;
        end while (!co[0] && n < 8);
        check("clk_out_lat", n, 3);
        @(negedge clk);

        clear_chain();
        shift_word(13'h1A5C, 1'b1);
        load_chain();
        check("single_load", {19'b0, pc[0]}, 32'h1A5C);

        clear_chain();
        shift_word(13'h1234, 1'b0);
        shift_word(13'h0ABC, 1'b0);
        shift_word(13'h15A3, 1'b0);
        load_chain();
        check("chain_c", {19'b0, pc[0]}, 32'h15A3);
        check("chain_b", {19'b0, pc[1]}, 32'h0ABC);
        check("chain_a", {19'b0, pc[2]}, 32'h1234);

        shift_word(13'h1FFF, 1'b0);
        clear_chain();
        check("clr_shift", {19'b0, u0.shift_q}, 0);
        check("clr_keep_pc", {19'b0, pc[0]}, 32'h15A3);

        for (int k = 0; k < 6; k++) sbit(1'b1, 1'b0);
        sclk = 1'b0;
        sdat = 1'b0;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_sh[i] = '0;
            m_do[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("midrst_pc", {19'b0, pc[0]}, 32'h1801);
        check("midrst_shift", {19'b0, u0.shift_q}, 0);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        shift_word(13'h0003, 1'b0);
        load_chain();
        check("midrst_load", {19'b0, pc[0]}, 32'h0003);

        repeat (20) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_serial_ctrl.md
# gpio_serial_ctrl

Per-pad receiver stage of the GPIO serial configuration chain, instantiated once per user I/O pad downstream of the management SoC's serial loader. It oversamples the loader's serial clock, reset and data in the `clk` domain and shifts `CTRL_BITS` configuration bits through a local shift register. It forwards serial clock, reset and data to the next pad in the chain and latches the shifted word into a shadow control register on the load pulse. The latched word drives the pad's mode fields.

## Interface

Parameters:

- `CTRL_BITS`, 13 — width of the shift and shadow registers.
- `RESET_VAL`, 13'h0403 — shadow register reset value. Use 13'h1801 for bidirectional pads 0–1 and 13'h0403 for simple input pads.
- `SYNC_STAGES`, 2 — input sampling stages, legal range 1–3.

Ports:

- `clk` input, 1 — system clock.
- `resetn` input, 1 — reset, asynchronous, active-low.
- `serial_clock_in` input, 1 — chain clock from the upstream pad or the loader.
- `serial_resetn_in` input, 1 — chain reset/load strobe.
- `serial_data_in` input, 1 — chain data; changes with the falling edge of the chain clock.
- `serial_clock_out` output, 1 — chain clock to the downstream pad.
- `serial_resetn_out` output, 1 — chain reset to the downstream pad.
- `serial_data_out` output, 1 — chain data to the downstream pad.
- `pad_ctrl` output, `CTRL_BITS` — shadow register contents.
- `mgmt_ena` output, 1 — `pad_ctrl[0]`.
- `gpio_outenb` output, 1 — `pad_ctrl[1]`.
- `gpio_holdover` output, 1 — `pad_ctrl[2]`.
- `gpio_inenb` output, 1 — `pad_ctrl[3]`.
- `gpio_ib_mode_sel` output, 1 — `pad_ctrl[4]`.
- `gpio_ana_en` output, 1 — `pad_ctrl[5]`.
- `gpio_ana_sel` output, 1 — `pad_ctrl[6]`.
- `gpio_ana_pol` output, 1 — `pad_ctrl[7]`.
- `gpio_slow_sel` output, 1 — `pad_ctrl[8]`.
- `gpio_vtrip_sel` output, 1 — `pad_ctrl[9]`.
- `gpio_dm` output, 3 — `pad_ctrl[12:10]`.
- `load_pulse` output, 1 — one-cycle strobe, high in the cycle `pad_ctrl` updates.

## Operation

- **Sampling:** each serial input passes through `SYNC_STAGES` flops, giving `s_clk`, `s_rst` and `s_dat`. One extra flop gives `s_clk_d` and `s_rst_d`.
  - `rise = s_clk & ~s_clk_d`
  - `fall = ~s_clk & s_clk_d`
  - `rfall = ~s_rst & s_rst_d`
- **Shift:** on `rise` with `s_rst`=1, `shift <= {shift[CTRL_BITS-2:0], s_dat}` (MSB first).
- **Forward data:** on `fall`, `serial_data_out <= shift[CTRL_BITS-1]`. Output data therefore changes with the falling edge of the forwarded clock, matching the loader's convention.
- **Forward clock/reset:** `serial_clock_out` = `s_clk_d`; `serial_resetn_out` = `s_rst_d`.
- **Load:** `rfall` while `s_clk`=1 gives `pad_ctrl <= shift` and `load_pulse`=1 for that one cycle.
- **Chain clear:** `s_rst`=0 while `s_clk`=0 clears `shift` to 0. `pad_ctrl` is kept.
- **Priority within a cycle:** clear > load > shift.
  - `rise` coinciding with `s_rst`=0: no shift.
  - `rfall` with `s_clk`=0: treated as clear, no load.
- **Reset (`resetn`=0, asynchronous):** all sampling flops 0, `shift`=0, `serial_data_out`=0, `pad_ctrl`=`RESET_VAL`, `load_pulse`=0. Forwarded clock and reset therefore read 0. A reset mid-shift discards the partial word.

## Timing

- Input-to-`shift` latency: `SYNC_STAGES`+1 cycles after `serial_clock_in` rises.
- Input-to-`serial_clock_out` latency: `SYNC_STAGES`+1 cycles.
- `serial_data_out` changes in the same cycle `serial_clock_out` falls, so the downstream stage sees data stable for the whole high phase.
- Minimum serial clock high and low phase: 1 `clk` cycle. Shorter glitches are not guaranteed to be detected.
- `pad_ctrl` and `load_pulse` update `SYNC_STAGES`+1 cycles after `serial_resetn_in` falls.
- Per-pad bit delay through the chain: exactly `CTRL_BITS` serial clock periods from `serial_data_in` to `serial_data_out`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure

- Shared package `gpio_cfg_pkg` holds:
  - `CTRL_BITS`;
  - field offsets `MGMT_ENA`=0, `OEB`=1, `HLDH`=2, `INP_DIS`=3, `IB_MODE`=4, `ANA_EN`=5, `ANA_SEL`=6, `ANA_POL`=7, `SLOW`=8, `VTRIP`=9, `DM_LSB`=10, `DM_W`=3;
  - defaults `CFG_BIDIR`=13'h1801 and `CFG_INPUT`=13'h0403.
- The loader and this block both import the package so field positions stay in one place.
- One sub-module, `serial_sync`: a `SYNC_STAGES`-deep 1-bit synchronizer with async active-low reset to 0, instantiated three times.

## Test plan

- **Reset value:** assert `resetn`=0 with `RESET_VAL`=13'h1801 → `pad_ctrl`=13'h1801, `gpio_dm`=3'b110, `mgmt_ena`=1, all serial outputs 0; same for 13'h0403 → `gpio_outenb`=1, `gpio_dm`=3'b001.
- **Shift and load:** clear the chain, shift 13'h1A5C MSB-first at 1 `clk` per phase, then pulse `serial_resetn_in` low with the clock high → `pad_ctrl`=13'h1A5C and `load_pulse` high for exactly 1 cycle.
- **Chain pass-through:** cascade 3 instances and shift 39 bits (words A, B, C) → after load, instance 0 holds C, instance 1 holds B, instance 2 holds A; each `serial_data_out` lags its input by 13 serial periods.
- **Clear without load:** shift 13'h1FFF, then drop `serial_resetn_in` with the clock low → `shift`=0, `pad_ctrl` unchanged, `load_pulse` stays 0.
- **Reset mid-operation:** assert `resetn` after 6 shifted bits, then shift and load 13'h0003 → `pad_ctrl`=13'h0003, with no residue of the earlier bits.
- **Edge timing:** drive the clock rise and data change in the same cycle → the sampled bit is the new value; forwarded data changes only in the cycle `serial_clock_out` falls.
